// File: rtl/imem_loader.sv
// Boot loader: streams a length-prefixed little-endian word image into instruction memory.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned NUMWORDS  = 4096,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_data_i,
  output logic                 byte_ready_o,
  output logic                 we_o,
  output logic [31:0]          waddr_o,
  output logic [DATAWIDTH-1:0] wdata_o,
  output logic                 cpu_rst_o,
  output logic                 done_o,
  output logic                 error_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  // State reached once the image body is complete, and whether it still takes bytes.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t FINAL_STATE = S_CSUM;
  localparam logic   FINAL_READY = 1'b1;
`else
  localparam state_t FINAL_STATE = S_DONE;
  localparam logic   FINAL_READY = 1'b0;
`endif

  state_t      state;
  logic [1:0]  byte_idx;
  logic [23:0] byte_buf;
  logic [31:0] word_cnt;
  logic [31:0] word_idx;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  logic        byte_fire;
  logic [31:0] full_word;
  logic        last_word;

  assign byte_fire = byte_valid_i && byte_ready_o;
  assign full_word = {byte_data_i, byte_buf};
  assign last_word = (word_idx + 32'd1) == word_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      byte_ready_o <= 1'b0;
      we_o         <= 1'b0;
      waddr_o      <= '0;
      wdata_o      <= '0;
      cpu_rst_o    <= 1'b1;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      byte_idx     <= '0;
      byte_buf     <= '0;
      word_cnt     <= '0;
      word_idx     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      we_o <= 1'b0;
      if (byte_fire) begin
        byte_idx <= byte_idx + 2'd1;
        byte_buf <= {byte_data_i, byte_buf[23:8]};
      end

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          // Release the core only one cycle after the last write strobe.
          if (state == S_DONE) begin
            done_o    <= 1'b1;
            cpu_rst_o <= 1'b0;
          end
          if (start_i) begin
            state        <= S_LEN;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
            cpu_rst_o    <= 1'b1;
            byte_ready_o <= 1'b1;
            byte_idx     <= '0;
            word_idx     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
          end
        end

        S_LEN: begin
          if (byte_fire && byte_idx == 2'd3) begin
            word_cnt <= full_word;
            if (full_word > 32'(NUMWORDS)) begin
              state        <= S_ERROR;
              error_o      <= 1'b1;
              byte_ready_o <= 1'b0;
            end else if (full_word == 32'd0) begin
              state        <= FINAL_STATE;
              byte_ready_o <= FINAL_READY;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (byte_fire) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ byte_data_i;
`endif
            if (byte_idx == 2'd3) begin
              wdata_o  <= DATAWIDTH'(full_word);
              waddr_o  <= 32'(BASE_ADDR) + {word_idx[29:0], 2'b00};
              we_o     <= 1'b1;
              word_idx <= word_idx + 32'd1;
              if (last_word) begin
                state        <= FINAL_STATE;
                byte_ready_o <= FINAL_READY;
              end
            end
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (byte_fire) begin
            byte_ready_o <= 1'b0;
            if (byte_data_i == csum) begin
              state <= S_DONE;
            end else begin
              state   <= S_ERROR;
              error_o <= 1'b1;
            end
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: scoreboard of expected writes checked against we_o pulses.
module tb_imem_loader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        we_o;
  logic [31:0] waddr_o;
  logic [31:0] wdata_o;
  logic        cpu_rst_o;
  logic        done_o;
  logic        error_o;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  wr_t exp_q[$];

  imem_loader #(.DATAWIDTH(32), .NUMWORDS(4096), .BASE_ADDR(0)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .we_o         (we_o),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o),
    .cpu_rst_o    (cpu_rst_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the oldest expected write, in the cycle after its 4th byte.
  always @(negedge clk_i) begin
    if (we_o === 1'b1) begin
      wr_t e;
      chk1("unexpected_we", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("waddr", waddr_o, e.addr);
        chk("wdata", wdata_o, e.data);
        chk("we_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    int   guard;
    logic r;
    guard        = 0;
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    do begin
      r = byte_ready_o;
      @(posedge clk_i); #1;
      guard++;
    end while (!r && guard < 50);
    chk1("byte_accept_timeout", r, 1'b1);
    byte_valid_i = 1'b0;
    acc_cyc      = cyc;
  endtask

  task automatic run_load(input logic [7:0] bs[$], input bit gap, input bit do_start, input int nbytes);
    logic [31:0] cnt;
    int          c;
    int          k;
    if (do_start) begin
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
    end
    cnt = {bs[3], bs[2], bs[1], bs[0]};
    for (int i = 0; i < nbytes; i++) begin
      if (gap && i > 0) begin
        @(posedge clk_i); #1;
      end
      send_byte(bs[i], c);
      k = (i - 4) / 4;
      if (i >= 4 && (i - 4) % 4 == 3 && 32'(k) < cnt)
        exp_q.push_back('{addr: 32'(4 * k),
                          data: {bs[i], bs[i-1], bs[i-2], bs[i-3]},
                          cyc: c});
    end
  endtask

  task automatic check_done(input string t);
    chk1({t, "_done_early"}, done_o, 1'b0);
    chk1({t, "_cpu_rst_early"}, cpu_rst_o, 1'b1);
    @(posedge clk_i); #1;
    chk1({t, "_done"}, done_o, 1'b1);
    chk1({t, "_cpu_rst"}, cpu_rst_o, 1'b0);
    chk1({t, "_error"}, error_o, 1'b0);
    chk1({t, "_ready"}, byte_ready_o, 1'b0);
    chk({t, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset(input string t);
    chk1({t, "_ready"}, byte_ready_o, 1'b0);
    chk1({t, "_we"}, we_o, 1'b0);
    chk1({t, "_done"}, done_o, 1'b0);
    chk1({t, "_error"}, error_o, 1'b0);
    chk1({t, "_cpu_rst"}, cpu_rst_o, 1'b1);
    chk({t, "_waddr"}, waddr_o, 32'd0);
    chk({t, "_wdata"}, wdata_o, 32'd0);
  endtask

  logic [7:0] s2[$];
  logic [7:0] s3[$];
  logic [7:0] s4[$];
  logic [7:0] x;

  initial begin
    s2 = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'hEF, 8'hBE, 8'hAD, 8'hDE};
    s3 = '{8'h00, 8'h00, 8'h00, 8'h00};
    s4 = '{8'h01, 8'h10, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    x = 8'h00;
    for (int i = 4; i < 12; i++) x = x ^ s2[i];
    s2.push_back(x);
    s3.push_back(8'h00);
`else
    x = 8'h00;
`endif

    rst_i        = 1'b1;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset("reset");
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Two-word load, back-to-back bytes.
    run_load(s2, 1'b0, 1'b1, s2.size());
    check_done("two_word");
    chk("two_word_waddr_hold", waddr_o, 32'h4);
    chk("two_word_wdata_hold", wdata_o, 32'hDEADBEEF);

`ifdef IMEM_LOADER_CHECKSUM_EN
    s2[12] = x ^ 8'hFF;
    run_load(s2, 1'b0, 1'b1, s2.size());
    chk1("bad_csum_error", error_o, 1'b1);
    chk1("bad_csum_cpu_rst", cpu_rst_o, 1'b1);
    chk1("bad_csum_done", done_o, 1'b0);
    chk1("bad_csum_ready", byte_ready_o, 1'b0);
    s2[12] = x;
`endif

    // Zero length.
    run_load(s3, 1'b0, 1'b1, s3.size());
    check_done("zero_len");

    // Gapped stream.
    run_load(s2, 1'b1, 1'b1, s2.size());
    check_done("gapped");
    chk("gapped_wdata_hold", wdata_o, 32'hDEADBEEF);

    // Oversize count, then recovery via start_i.
    run_load(s4, 1'b0, 1'b1, s4.size());
    chk1("oversize_error", error_o, 1'b1);
    chk1("oversize_ready", byte_ready_o, 1'b0);
    chk1("oversize_cpu_rst", cpu_rst_o, 1'b1);
    chk1("oversize_done", done_o, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;
    chk1("oversize_error_held", error_o, 1'b1);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk1("restart_error_clear", error_o, 1'b0);
    chk1("restart_ready", byte_ready_o, 1'b1);
    chk1("restart_cpu_rst", cpu_rst_o, 1'b1);

    // Reset after 6 bytes, then a full reload.
    run_load(s2, 1'b0, 1'b0, 6);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check_reset("mid_reset");
    run_load(s2, 1'b0, 1'b1, s2.size());
    check_done("reload");
    chk("reload_waddr_hold", waddr_o, 32'h4);
    chk("reload_wdata_hold", wdata_o, 32'hDEADBEEF);

    repeat (2) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
